// File: rtl/mem.sv
// rtl/mem.sv - memory-access pipeline stage between execute and write-back
// Issues loads/stores on a req/ack data port and registers results into MEM/WB.
module mem (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_vld,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_nxt_pc,
  input  logic [31:0] i_res,
  input  logic [31:0] i_rs2_rdata,
  input  logic [4:0]  i_rd_waddr,
  input  logic        i_rd_wen,
  input  logic        i_mem_ren,
  input  logic        i_mem_wen,
  input  logic [2:0]  i_funct3,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic [31:0] o_dmem_addr,
  output logic        o_dmem_ren,
  output logic        o_dmem_wen,
  output logic [3:0]  o_dmem_mask,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_wb_vld,
  output logic        o_wb_mem_reg,
  output logic        o_wb_rd_wen,
  output logic        o_wb_trap,
  output logic [31:0] o_wb_res,
  output logic [31:0] o_wb_dmem_rdata,
  output logic [4:0]  o_wb_rd_waddr,
  output logic [31:0] o_wb_inst,
  output logic [31:0] o_wb_pc,
  output logic [31:0] o_wb_nxt_pc
);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e      state_q, state_d;
  logic        dmem_req_q, dmem_req_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic        dmem_ren_q, dmem_ren_d;
  logic        dmem_wen_q, dmem_wen_d;
  logic [3:0]  dmem_mask_q, dmem_mask_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  funct3_q, funct3_d;

  logic        wb_vld_q, wb_vld_d;
  logic        wb_mem_reg_q, wb_mem_reg_d;
  logic        wb_rd_wen_q, wb_rd_wen_d;
  logic        wb_trap_q, wb_trap_d;
  logic [31:0] wb_res_q, wb_res_d;
  logic [31:0] wb_dmem_rdata_q, wb_dmem_rdata_d;
  logic [4:0]  wb_rd_waddr_q, wb_rd_waddr_d;
  logic [31:0] wb_inst_q, wb_inst_d;
  logic [31:0] wb_pc_q, wb_pc_d;
  logic [31:0] wb_nxt_pc_q, wb_nxt_pc_d;

  logic [1:0]  off;
  logic        is_mem, bad_f3, misalign, trap, rd_wen_eff;
  logic [3:0]  mask_in;
  logic [31:0] wdata_in;

  always_comb begin
    off      = i_res[1:0];
    is_mem   = i_mem_ren | i_mem_wen;
    // 011/110/111 are never legal; the unsigned sizes only exist for loads
    bad_f3   = (i_funct3[1:0] == 2'b11) | (i_funct3[2] & i_funct3[1]) |
               (i_funct3[2] & i_mem_wen);
    misalign = ((i_funct3[1:0] == 2'b01) & off[0]) |
               ((i_funct3[1:0] == 2'b10) & (off != 2'b00));
    trap     = is_mem & (bad_f3 | misalign | (i_mem_ren & i_mem_wen));
    rd_wen_eff = i_rd_wen & (i_rd_waddr != 5'd0) & ~i_mem_wen & ~trap;
    mask_in  = 4'b0000;
    wdata_in = i_rs2_rdata;
    case (i_funct3[1:0])
      2'b00: begin
        mask_in  = 4'b0001 << off;
        wdata_in = {4{i_rs2_rdata[7:0]}};
      end
      2'b01: begin
        mask_in  = off[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{i_rs2_rdata[15:0]}};
      end
      2'b10:   mask_in = 4'b1111;
      default: mask_in = 4'b0000;
    endcase
  end

  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;

  always_comb begin
    case (off_q)
      2'd0:    ld_b = i_dmem_rdata[7:0];
      2'd1:    ld_b = i_dmem_rdata[15:8];
      2'd2:    ld_b = i_dmem_rdata[23:16];
      default: ld_b = i_dmem_rdata[31:24];
    endcase
    ld_h = off_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_data = {24'd0, ld_b};
      3'b101:  ld_data = {16'd0, ld_h};
      default: ld_data = i_dmem_rdata;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    dmem_req_d      = dmem_req_q;
    dmem_addr_d     = dmem_addr_q;
    dmem_ren_d      = dmem_ren_q;
    dmem_wen_d      = dmem_wen_q;
    dmem_mask_d     = dmem_mask_q;
    dmem_wdata_d    = dmem_wdata_q;
    off_d           = off_q;
    funct3_d        = funct3_q;
    wb_vld_d        = 1'b0;
    wb_mem_reg_d    = wb_mem_reg_q;
    wb_rd_wen_d     = wb_rd_wen_q;
    wb_trap_d       = wb_trap_q;
    wb_res_d        = wb_res_q;
    wb_dmem_rdata_d = wb_dmem_rdata_q;
    wb_rd_waddr_d   = wb_rd_waddr_q;
    wb_inst_d       = wb_inst_q;
    wb_pc_d         = wb_pc_q;
    wb_nxt_pc_d     = wb_nxt_pc_q;
    case (state_q)
      IDLE: begin
        if (i_vld) begin
          // Pass-through fields are captured now so WB sees them after the access too
          wb_res_d      = i_res;
          wb_rd_waddr_d = i_rd_waddr;
          wb_inst_d     = i_inst;
          wb_pc_d       = i_pc;
          wb_nxt_pc_d   = i_nxt_pc;
          wb_rd_wen_d   = rd_wen_eff;
          wb_trap_d     = trap;
          wb_mem_reg_d  = 1'b0;
          if (is_mem && !trap) begin
            state_d      = ACCESS;
            dmem_req_d   = 1'b1;
            dmem_addr_d  = {i_res[31:2], 2'b00};
            dmem_ren_d   = i_mem_ren;
            dmem_wen_d   = i_mem_wen;
            dmem_mask_d  = mask_in;
            dmem_wdata_d = wdata_in;
            off_d        = off;
            funct3_d     = i_funct3;
          end else begin
            wb_vld_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (i_dmem_ack) begin
          state_d      = IDLE;
          dmem_req_d   = 1'b0;
          dmem_ren_d   = 1'b0;
          dmem_wen_d   = 1'b0;
          dmem_mask_d  = 4'b0000;
          wb_vld_d     = 1'b1;
          wb_mem_reg_d = dmem_ren_q;
          if (dmem_ren_q) wb_dmem_rdata_d = ld_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q         <= IDLE;
      dmem_req_q      <= 1'b0;
      dmem_addr_q     <= 32'd0;
      dmem_ren_q      <= 1'b0;
      dmem_wen_q      <= 1'b0;
      dmem_mask_q     <= 4'b0000;
      dmem_wdata_q    <= 32'd0;
      off_q           <= 2'd0;
      funct3_q        <= 3'd0;
      wb_vld_q        <= 1'b0;
      wb_mem_reg_q    <= 1'b0;
      wb_rd_wen_q     <= 1'b0;
      wb_trap_q       <= 1'b0;
      wb_res_q        <= 32'd0;
      wb_dmem_rdata_q <= 32'd0;
      wb_rd_waddr_q   <= 5'd0;
      wb_inst_q       <= 32'd0;
      wb_pc_q         <= 32'd0;
      wb_nxt_pc_q     <= 32'd0;
    end else begin
      state_q         <= state_d;
      dmem_req_q      <= dmem_req_d;
      dmem_addr_q     <= dmem_addr_d;
      dmem_ren_q      <= dmem_ren_d;
      dmem_wen_q      <= dmem_wen_d;
      dmem_mask_q     <= dmem_mask_d;
      dmem_wdata_q    <= dmem_wdata_d;
      off_q           <= off_d;
      funct3_q        <= funct3_d;
      wb_vld_q        <= wb_vld_d;
      wb_mem_reg_q    <= wb_mem_reg_d;
      wb_rd_wen_q     <= wb_rd_wen_d;
      wb_trap_q       <= wb_trap_d;
      wb_res_q        <= wb_res_d;
      wb_dmem_rdata_q <= wb_dmem_rdata_d;
      wb_rd_waddr_q   <= wb_rd_waddr_d;
      wb_inst_q       <= wb_inst_d;
      wb_pc_q         <= wb_pc_d;
      wb_nxt_pc_q     <= wb_nxt_pc_d;
    end
  end

  assign o_stall         = (state_q == ACCESS);
  assign o_dmem_req      = dmem_req_q;
  assign o_dmem_addr     = dmem_addr_q;
  assign o_dmem_ren      = dmem_ren_q;
  assign o_dmem_wen      = dmem_wen_q;
  assign o_dmem_mask     = dmem_mask_q;
  assign o_dmem_wdata    = dmem_wdata_q;
  assign o_wb_vld        = wb_vld_q;
  assign o_wb_mem_reg    = wb_mem_reg_q;
  assign o_wb_rd_wen     = wb_rd_wen_q;
  assign o_wb_trap       = wb_trap_q;
  assign o_wb_res        = wb_res_q;
  assign o_wb_dmem_rdata = wb_dmem_rdata_q;
  assign o_wb_rd_waddr   = wb_rd_waddr_q;
  assign o_wb_inst       = wb_inst_q;
  assign o_wb_pc         = wb_pc_q;
  assign o_wb_nxt_pc     = wb_nxt_pc_q;

endmodule
